// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// FETCH_MISALIGN_CHECK_EN adds a misaligned flag to each buffered fetch entry.
package instr_fetch_pkg;

    localparam int unsigned REG_WIDTH   = 32;
    localparam int unsigned INSTR_WIDTH = 32;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [REG_WIDTH-1:0]   pc;
        logic [INSTR_WIDTH-1:0] instr;
`ifdef FETCH_MISALIGN_CHECK_EN
        logic                   misaligned;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush wins over push, a pop while empty is ignored.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  fetch_entry_t             entry_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // The fetch space check must make an unabsorbed push into a full buffer impossible.
    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !flush_i && full_o && !pop_i));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem request, PC update, redirect/flush, instruction buffer.
// FETCH_MISALIGN_CHECK_EN turns a misaligned PC into a flagged NOP instead of a memory request.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter int unsigned INSTR_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_WIDTH-1:0]   i_pc,
    output logic                   o_pc_we,
    output logic [REG_WIDTH-1:0]   o_pc_wdata,
    output logic                   o_imem_req_valid,
    output logic [REG_WIDTH-1:0]   o_imem_req_addr,
    input  logic                   i_imem_req_ready,
    input  logic                   i_imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
    input  logic                   i_redirect_valid,
    input  logic [REG_WIDTH-1:0]   i_redirect_pc,
    output logic                   o_instr_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [REG_WIDTH-1:0]   o_instr_pc,
    input  logic                   i_instr_ready
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                   o_instr_misaligned
`endif
);

    localparam logic [1:0] ST_REQ   = REQ;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]             state_q, state_d;
    logic [REG_WIDTH-1:0]   req_pc_q, req_pc_d;
    logic                   req_valid;
    logic                   pc_we;
    logic [REG_WIDTH-1:0]   pc_wdata;
    logic                   has_space;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    fetch_entry_t           push_entry;
    fetch_entry_t           head;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                   mis_hold_q, mis_hold_d;
`endif

    assign has_space = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_pop  = i_instr_ready && !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_REQ;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_hold_q <= 1'b0;
        end else begin
            mis_hold_q <= mis_hold_d;
        end
    end
`endif

    // Next state, PC write and buffer push; a redirect overrides everything else.
    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        req_valid  = 1'b0;
        pc_we      = 1'b0;
        pc_wdata   = '0;
        fifo_push  = 1'b0;
        push_entry = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_hold_d = mis_hold_q;
`endif
        if (i_redirect_valid) begin
            pc_we    = 1'b1;
            pc_wdata = i_redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_hold_d = 1'b0;
`endif
            // An in-flight request must still have its response swallowed.
            if ((state_q == ST_WAIT || state_q == ST_DRAIN) && !i_imem_rsp_valid) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (i_pc[1:0] != 2'b00) begin
                        if (!mis_hold_q && has_space) begin
                            fifo_push             = 1'b1;
                            push_entry.pc         = i_pc;
                            push_entry.instr      = NOP_INSTR;
                            push_entry.misaligned = 1'b1;
                            mis_hold_d            = 1'b1;
                        end
                    end else
`endif
                    begin
                        req_valid = has_space;
                        if (has_space && i_imem_req_ready) begin
                            pc_we    = 1'b1;
                            pc_wdata = i_pc + REG_WIDTH'(INSTR_BYTES);
                            req_pc_d = i_pc;
                            state_d  = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_imem_rsp_valid) begin
                        fifo_push        = 1'b1;
                        push_entry.pc    = req_pc_q;
                        push_entry.instr = i_imem_rsp_data;
                        state_d          = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (i_imem_rsp_valid) begin
                        state_d = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    assign o_imem_req_valid = req_valid && !rst;
    assign o_imem_req_addr  = i_pc;
    assign o_pc_we          = pc_we && !rst;
    assign o_pc_wdata       = rst ? '0 : pc_wdata;
    assign o_instr_valid    = !fifo_empty;
    assign o_instr          = head.instr;
    assign o_instr_pc       = head.pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign o_instr_misaligned = head.misaligned;
`endif

    instr_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .entry_i (push_entry),
        .pop_i   (fifo_pop),
        .flush_i (i_redirect_valid),
        .head_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The full flag and the occupancy count must always agree.
    full_count_a: assert property (@(posedge clk) disable iff (rst)
        fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: models program_counter, instruction memory and decode around the DUT.
// Directed scenarios plus a randomized run scored against an in-order PC stream model.
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_pc;
    logic        o_pc_we;
    logic [31:0] o_pc_wdata;
    logic        o_imem_req_valid;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_req_ready;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        o_instr_misaligned;
`endif

    always #5 clk = ~clk;

    instr_fetch #(
        .FIFO_DEPTH  (2),
        .INSTR_BYTES (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_pc             (i_pc),
        .o_pc_we          (o_pc_we),
        .o_pc_wdata       (o_pc_wdata),
        .o_imem_req_valid (o_imem_req_valid),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_req_ready (i_imem_req_ready),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_instr_valid    (o_instr_valid),
        .o_instr          (o_instr),
        .o_instr_pc       (o_instr_pc),
        .i_instr_ready    (i_instr_ready)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .o_instr_misaligned (o_instr_misaligned)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Environment: PC register, single-response memory, one-shot redirect request.
    logic [31:0] pc_m;
    int          rsp_wait;
    logic [31:0] rsp_addr;
    int          mem_lat;
    logic        redir_req;
    logic [31:0] redir_tgt;

    // What was seen during the most recent cycle.
    logic        ob_hs, ob_pop, ob_we, ob_redir, ob_rsp, ob_req_valid, ob_instr_valid, ob_busy;
    logic        ob_mis = 1'b0;
    logic [31:0] ob_addr, ob_wdata, ob_head_pc, ob_head_instr, ob_pc, ob_tgt;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h0000_00A0 + addr;
    endfunction

    // Called at a falling edge; drives one cycle, records it, returns at the next falling edge.
    task automatic cycle();
        ob_busy          = (rsp_wait != 0);
        i_imem_rsp_valid = (rsp_wait == 1);
        i_imem_rsp_data  = (rsp_wait == 1) ? mem_word(rsp_addr) : 32'hDEAD_BEEF;
        i_pc             = pc_m;
        i_redirect_valid = redir_req;
        i_redirect_pc    = redir_tgt;
        ob_redir         = redir_req;
        ob_tgt           = redir_tgt;
        redir_req        = 1'b0;
        #1;
        ob_req_valid   = o_imem_req_valid;
        ob_hs          = o_imem_req_valid & i_imem_req_ready;
        ob_addr        = o_imem_req_addr;
        ob_pc          = pc_m;
        ob_instr_valid = o_instr_valid;
        ob_pop         = o_instr_valid & i_instr_ready;
        ob_head_pc     = o_instr_pc;
        ob_head_instr  = o_instr;
        ob_we          = o_pc_we;
        ob_wdata       = o_pc_wdata;
        ob_rsp         = i_imem_rsp_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
        ob_mis         = o_instr_misaligned;
`endif
        @(negedge clk);
        if (ob_we) pc_m = ob_wdata;
        if (ob_hs) begin
            rsp_addr = ob_addr;
            rsp_wait = mem_lat;
        end else if (rsp_wait > 0) begin
            rsp_wait--;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pc_m = 32'h0; rsp_wait = 0; rsp_addr = 32'h0; mem_lat = 1;
        redir_req = 1'b0; redir_tgt = 32'h0;
        i_pc = 32'h0; i_imem_req_ready = 1'b1; i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data = 32'h0; i_redirect_valid = 1'b0; i_redirect_pc = 32'h0;
        i_instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_pc = 32'h0; i_imem_req_ready = 1'b1; i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data = 32'h0; i_redirect_valid = 1'b0; i_redirect_pc = 32'h0;
        i_instr_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({o_pc_we, o_imem_req_valid, o_instr_valid} !== 3'b000 ||
            o_pc_wdata !== 32'h0 || o_imem_req_addr !== 32'h0 ||
            o_instr !== 32'h0 || o_instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: we=%b rv=%b iv=%b wdata=%h addr=%h instr=%h ipc=%h, want all zero",
                     o_pc_we, o_imem_req_valid, o_instr_valid, o_pc_wdata, o_imem_req_addr, o_instr, o_instr_pc);
        end
    endtask

    task automatic test_sequential();
        int pops = 0;
        int wes  = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (ob_we) begin
                checks++;
                if (ob_wdata !== 32'(4 * (wes + 1))) begin
                    failures++;
                    $display("FAIL seq_pc_wdata: got %h, want %h", ob_wdata, 32'(4 * (wes + 1)));
                end
                wes++;
            end
            if (ob_pop) begin
                checks++;
                if (ob_head_pc !== 32'(4 * pops) || ob_head_instr !== mem_word(32'(4 * pops)) ||
                    c != 2 + 2 * pops) begin
                    failures++;
                    $display("FAIL seq_pop: got pc=%h instr=%h cyc=%0d, want pc=%h instr=%h cyc=%0d",
                             ob_head_pc, ob_head_instr, c, 32'(4 * pops), mem_word(32'(4 * pops)), 2 + 2 * pops);
                end
                pops++;
            end
        end
        checks++;
        if (pops != 3 || wes != 4) begin
            failures++;
            $display("FAIL seq_counts: got pops=%0d pc_writes=%0d, want pops=3 pc_writes=4", pops, wes);
        end
    endtask

    task automatic test_backpressure();
        int hs_cnt = 0;
        do_reset();
        i_instr_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (ob_hs) hs_cnt++;
            if (c >= 4) begin
                checks++;
                if (ob_req_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_req_blocked: cyc=%0d got req_valid=%b, want 0", c, ob_req_valid);
                end
            end
        end
        checks++;
        if (hs_cnt != 2 || ob_instr_valid !== 1'b1 || ob_head_pc !== 32'h0) begin
            failures++;
            $display("FAIL bp_full: got handshakes=%0d valid=%b head_pc=%h, want 2 1 00000000",
                     hs_cnt, ob_instr_valid, ob_head_pc);
        end
        i_instr_ready = 1'b1;
        cycle();
        checks++;
        if (ob_pop !== 1'b1 || ob_head_pc !== 32'h0 || ob_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release_pop: got pop=%b pc=%h req_valid=%b, want 1 00000000 0",
                     ob_pop, ob_head_pc, ob_req_valid);
        end
        cycle();
        checks++;
        if (ob_hs !== 1'b1 || ob_addr !== 32'h8 || ob_head_pc !== 32'h4) begin
            failures++;
            $display("FAIL bp_resume: got hs=%b addr=%h head_pc=%h, want 1 00000008 00000004",
                     ob_hs, ob_addr, ob_head_pc);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        mem_lat = 4;
        cycle();
        checks++;
        if (ob_hs !== 1'b1 || ob_addr !== 32'h0) begin
            failures++;
            $display("FAIL rw_first_req: got hs=%b addr=%h, want 1 00000000", ob_hs, ob_addr);
        end
        redir_req = 1'b1; redir_tgt = 32'h100;
        cycle();
        checks++;
        if (ob_we !== 1'b1 || ob_wdata !== 32'h100 || ob_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rw_redirect: got we=%b wdata=%h req_valid=%b, want 1 00000100 0",
                     ob_we, ob_wdata, ob_req_valid);
        end
        for (int c = 2; c < 5; c++) begin
            cycle();
            checks++;
            if (ob_req_valid !== 1'b0 || ob_instr_valid !== 1'b0 || ob_rsp !== (c == 4)) begin
                failures++;
                $display("FAIL rw_drain: cyc=%0d got req_valid=%b instr_valid=%b rsp=%b, want 0 0 %b",
                         c, ob_req_valid, ob_instr_valid, ob_rsp, c == 4);
            end
        end
        mem_lat = 1;
        cycle();
        checks++;
        if (ob_hs !== 1'b1 || ob_addr !== 32'h100 || ob_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL rw_target_req: got hs=%b addr=%h instr_valid=%b, want 1 00000100 0",
                     ob_hs, ob_addr, ob_instr_valid);
        end
        cycle();
        cycle();
        checks++;
        if (ob_instr_valid !== 1'b1 || ob_head_pc !== 32'h100 || ob_head_instr !== 32'h1A0) begin
            failures++;
            $display("FAIL rw_target_instr: got valid=%b pc=%h instr=%h, want 1 00000100 000001a0",
                     ob_instr_valid, ob_head_pc, ob_head_instr);
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        cycle();
        redir_req = 1'b1; redir_tgt = 32'h40;
        cycle();
        checks++;
        if (ob_rsp !== 1'b1 || ob_we !== 1'b1 || ob_wdata !== 32'h40 || ob_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rs_redirect: got rsp=%b we=%b wdata=%h req_valid=%b, want 1 1 00000040 0",
                     ob_rsp, ob_we, ob_wdata, ob_req_valid);
        end
        cycle();
        checks++;
        if (ob_instr_valid !== 1'b0 || ob_req_valid !== 1'b1 || ob_addr !== 32'h40) begin
            failures++;
            $display("FAIL rs_next: got instr_valid=%b req_valid=%b addr=%h, want 0 1 00000040",
                     ob_instr_valid, ob_req_valid, ob_addr);
        end
        cycle();
        cycle();
        checks++;
        if (ob_instr_valid !== 1'b1 || ob_head_pc !== 32'h40 || ob_head_instr !== 32'hE0) begin
            failures++;
            $display("FAIL rs_target_instr: got valid=%b pc=%h instr=%h, want 1 00000040 000000e0",
                     ob_instr_valid, ob_head_pc, ob_head_instr);
        end
    endtask

    task automatic test_req_stall();
        do_reset();
        i_imem_req_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            checks++;
            if (ob_req_valid !== 1'b1 || ob_addr !== 32'h0 || ob_we !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold: cyc=%0d got req_valid=%b addr=%h we=%b, want 1 00000000 0",
                         c, ob_req_valid, ob_addr, ob_we);
            end
        end
        i_imem_req_ready = 1'b1;
        cycle();
        checks++;
        if (ob_hs !== 1'b1 || ob_we !== 1'b1 || ob_wdata !== 32'h4) begin
            failures++;
            $display("FAIL stall_accept: got hs=%b we=%b wdata=%h, want 1 1 00000004", ob_hs, ob_we, ob_wdata);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redir_req = 1'b1; redir_tgt = 32'hFFFF_FFFC;
        cycle();
        checks++;
        if (ob_req_valid !== 1'b0 || ob_wdata !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_redirect: got req_valid=%b wdata=%h, want 0 fffffffc", ob_req_valid, ob_wdata);
        end
        cycle();
        checks++;
        if (ob_hs !== 1'b1 || ob_addr !== 32'hFFFF_FFFC || ob_wdata !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pc_next: got hs=%b addr=%h wdata=%h, want 1 fffffffc 00000000",
                     ob_hs, ob_addr, ob_wdata);
        end
        cycle();
        cycle();
        checks++;
        if (ob_head_pc !== 32'hFFFF_FFFC || ob_head_instr !== 32'h9C) begin
            failures++;
            $display("FAIL wrap_instr: got pc=%h instr=%h, want fffffffc 0000009c", ob_head_pc, ob_head_instr);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        logic        prev_redir = 1'b0;
        int          pops = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            i_imem_req_ready = ($urandom_range(0, 3) != 0);
            i_instr_ready    = ($urandom_range(0, 2) != 0);
            mem_lat          = $urandom_range(1, 3);
            if ($urandom_range(0, 39) == 0) begin
                redir_req = 1'b1;
                redir_tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            end
            cycle();
            checks++;
            if (ob_addr !== ob_pc || (ob_hs && ob_busy)) begin
                failures++;
                $display("FAIL rnd_req: cyc=%0d got addr=%h hs=%b busy=%b, want addr=%h and no request while busy",
                         c, ob_addr, ob_hs, ob_busy, ob_pc);
            end
            checks++;
            if (ob_redir) begin
                if (ob_we !== 1'b1 || ob_wdata !== ob_tgt || ob_req_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_redirect: cyc=%0d got we=%b wdata=%h req_valid=%b, want 1 %h 0",
                             c, ob_we, ob_wdata, ob_req_valid, ob_tgt);
                end
            end else if (ob_we !== ob_hs || (ob_hs && ob_wdata !== ob_pc + 32'h4)) begin
                failures++;
                $display("FAIL rnd_pc_write: cyc=%0d got we=%b wdata=%h, want we=%b wdata=%h",
                         c, ob_we, ob_wdata, ob_hs, ob_pc + 32'h4);
            end
            if (prev_redir) begin
                checks++;
                if (ob_instr_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_flush: cyc=%0d got instr_valid=%b, want 0", c, ob_instr_valid);
                end
            end
            if (ob_pop) begin
                checks++;
                if (ob_head_pc !== exp_pc || ob_head_instr !== mem_word(exp_pc)) begin
                    failures++;
                    $display("FAIL rnd_stream: cyc=%0d got pc=%h instr=%h, want pc=%h instr=%h",
                             c, ob_head_pc, ob_head_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'h4;
                pops++;
            end
            if (ob_redir) exp_pc = ob_tgt;
            prev_redir = ob_redir;
        end
        checks++;
        if (pops < 200) begin
            failures++;
            $display("FAIL rnd_progress: got %0d delivered instructions, want at least 200", pops);
        end
    endtask

`ifdef FETCH_MISALIGN_CHECK_EN
    task automatic test_misaligned();
        do_reset();
        i_instr_ready = 1'b0;
        redir_req = 1'b1; redir_tgt = 32'h102;
        cycle();
        for (int c = 1; c < 5; c++) begin
            cycle();
            checks++;
            if (ob_req_valid !== 1'b0 || ob_instr_valid !== (c >= 2) ||
                (c >= 2 && (ob_head_pc !== 32'h102 || ob_head_instr !== 32'h13 || ob_mis !== 1'b1))) begin
                failures++;
                $display("FAIL mis_head: cyc=%0d got req_valid=%b valid=%b pc=%h instr=%h mis=%b, want 0 %b 00000102 00000013 1",
                         c, ob_req_valid, ob_instr_valid, ob_head_pc, ob_head_instr, ob_mis, c >= 2);
            end
        end
        i_instr_ready = 1'b1;
        cycle();
        cycle();
        checks++;
        if (ob_instr_valid !== 1'b0 || ob_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL mis_no_repush: got valid=%b req_valid=%b, want 0 0", ob_instr_valid, ob_req_valid);
        end
        redir_req = 1'b1; redir_tgt = 32'h200;
        cycle();
        cycle();
        checks++;
        if (ob_hs !== 1'b1 || ob_addr !== 32'h200) begin
            failures++;
            $display("FAIL mis_clear: got hs=%b addr=%h, want 1 00000200", ob_hs, ob_addr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_req_stall();
        test_wrap();
`ifdef FETCH_MISALIGN_CHECK_EN
        test_misaligned();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that consumes the program counter value and drives its write port (next PC or redirect target).
- Issues one-at-a-time requests to instruction memory and buffers returned instructions with their PC in a small FIFO.
- Presents buffered instructions to decode with a valid/ready handshake.
- Sits between program_counter, instruction memory and the decode stage; handles branch/jump redirects with flush.

Parameters:
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)
- INSTR_BYTES, 4, PC increment per fetched instruction

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_pc  in  REG_WIDTH  current PC from program_counter read port
- o_pc_we  out  1  program_counter write enable
- o_pc_wdata  out  REG_WIDTH  program_counter write data
- o_imem_req_valid  out  1  fetch request valid
- o_imem_req_addr  out  REG_WIDTH  fetch address (= i_pc)
- i_imem_req_ready  in  1  memory accepts request
- i_imem_rsp_valid  in  1  response valid (exactly one per accepted request, >=1 cycle later)
- i_imem_rsp_data  in  INSTR_WIDTH  instruction word
- i_redirect_valid  in  1  branch/jump redirect, single-cycle pulse
- i_redirect_pc  in  REG_WIDTH  redirect target
- o_instr_valid  out  1  buffered instruction available (FIFO non-empty)
- o_instr  out  INSTR_WIDTH  instruction at FIFO head
- o_instr_pc  out  REG_WIDTH  PC of instruction at FIFO head
- i_instr_ready  in  1  decode consumes head when o_instr_valid & i_instr_ready

Behaviour:
- Reset: state REQ, FIFO empty, no outstanding request; all outputs 0. o_imem_req_addr follows i_pc (0 after PC reset).
- FSM states: REQ, WAIT, DRAIN.
- REQ:
  - o_imem_req_valid = (fifo_count + 0 < FIFO_DEPTH) & !i_redirect_valid.
  - On handshake: o_pc_we=1, o_pc_wdata = i_pc + INSTR_BYTES (mod 2^REG_WIDTH, wraps), latch req_pc = i_pc, go to WAIT.
- WAIT:
  - On i_imem_rsp_valid: push {req_pc, rsp_data}, go to REQ.
  - No new request is issued in WAIT.
- DRAIN:
  - On i_imem_rsp_valid: discard the response, go to REQ.
- Redirect (highest priority, any state):
  - o_pc_we=1, o_pc_wdata=i_redirect_pc; FIFO flushed (o_instr_valid=0 next cycle).
  - No request issued that cycle.
  - WAIT without same-cycle response -> DRAIN; WAIT with same-cycle response -> response discarded, go to REQ.
  - DRAIN stays DRAIN (or goes to REQ if the response arrives that same cycle, discarded).
  - REQ -> REQ.
- Redirect deasserts o_imem_req_valid even if a request was pending un-accepted; memory must tolerate request withdrawal on redirect.
- o_imem_req_addr is stable while o_imem_req_valid=1 and ready=0.
- Latency: handshake in cycle N, response in cycle N+1 (best case) -> o_instr_valid in cycle N+2. Sustained throughput is 1 instruction per 2 cycles.
- FIFO:
  - Push and pop in the same cycle is legal, including when full.
  - A pop while empty is ignored.
  - The space check guarantees a push never overflows; an overflow indicates a design bug (assertion).

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- With the macro:
  - Extra output o_instr_misaligned (1 bit, head flag).
  - In REQ with i_pc[1:0] != 0: no memory request; push {i_pc, NOP_INSTR, misaligned=1}; hold in REQ without re-pushing until a redirect arrives.
- Without the macro: the port is absent, low PC bits are passed unchanged to memory, and no check is made.

Decomposition:
- const_pkg additions: INSTR_WIDTH=32, NOP_INSTR=32'h0000_0013, fetch_state_e (REQ/WAIT/DRAIN), fetch_entry_t struct {pc, instr[, misaligned]}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, full/empty, parameterised by depth. Flush has priority over push.

Test Plan:
- Reset, ready=1, memory returns 0xA0+addr after 1 cycle, decode ready=1 -> instructions PC 0,4,8 in order; o_pc_wdata 4,8,12.
- Decode ready=0 -> after two pushes, o_imem_req_valid stays 0 with the FIFO full. Releasing ready pops PC 0 and resumes fetching.
- Redirect to 0x100 during WAIT, response arrives 3 cycles later -> response discarded; next request address is 0x100; FIFO empty after the redirect.
- Redirect in the same cycle as a response in WAIT -> nothing pushed; state REQ; PC=target next cycle.
- i_imem_req_ready=0 for 4 cycles -> valid held and addr stable; PC not written until the handshake.
- FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> no memory request; head = {0x102, 0x00000013, misaligned=1}; a redirect to 0x200 clears the condition.
